// File: rtl/mem_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage_pkg
// Description : Shared constants, bus layout and access-size decode for the
//               MEM pipeline stage.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_stage_pkg;

  localparam int EX_TO_MEM_WD = 80;
  localparam int MEM_TO_WB_WD = 70;
  localparam int MEM_TO_ID_WD = 38;
  localparam int STALL_W      = 6;

  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  localparam logic [3:0] READEN_LW  = 4'b0001;
  localparam logic [3:0] READEN_LB  = 4'b0101;
  localparam logic [3:0] READEN_LH  = 4'b0111;
  localparam logic [3:0] READEN_LBU = 4'b1101;
  localparam logic [3:0] READEN_LHU = 4'b1111;

  localparam int RD_HALF_BIT = 1;
  localparam int RD_SUB_BIT  = 2;
  localparam int RD_UNS_BIT  = 3;

  typedef enum logic [1:0] {
    ACC_WORD = 2'd0,
    ACC_HALF = 2'd1,
    ACC_BYTE = 2'd2
  } acc_size_e;

  typedef struct packed {
    logic [3:0]  readen;
    logic [31:0] pc;
    logic        ram_en;
    logic [3:0]  ram_wen;
    logic        sel_rf_res;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] ex_result;
  } ex_mem_bus_t;

  // readen=0 falls out as a word access because the sub-word bit is clear.
  function automatic acc_size_e decode_size(input logic [3:0] readen);
    if (!readen[RD_SUB_BIT])      return ACC_WORD;
    else if (readen[RD_HALF_BIT]) return ACC_HALF;
    else                          return ACC_BYTE;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_stage_load_align.sv
`default_nettype none
// ============================================================================
// Module      : load_align
// Description : Byte/halfword/word lane selection with sign or zero extension.
// Revision    : 1.0 - initial release
// ============================================================================
module load_align
  import mem_stage_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  addr_i,
  input  logic [3:0]  readen_i,
  output logic [31:0] load_data_o
);

  logic [7:0]  w_byte_lane;
  logic [15:0] w_half_lane;
  logic        w_sext;
  acc_size_e   w_size;
  logic        w_unused_ok;

  assign w_byte_lane = rdata_i[{addr_i, 3'b000} +: 8];
  assign w_half_lane = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];
  assign w_sext      = ~readen_i[RD_UNS_BIT];
  assign w_size      = decode_size(readen_i);
  assign w_unused_ok = readen_i[0];

  always_comb begin
    load_data_o = rdata_i;
    case (w_size)
      ACC_BYTE: load_data_o = {{24{w_sext & w_byte_lane[7]}}, w_byte_lane};
      ACC_HALF: load_data_o = {{16{w_sext & w_half_lane[15]}}, w_half_lane};
      default:  load_data_o = rdata_i;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage
// Description : MEM pipeline stage: stage register, stall-safe SRAM read
//               capture, load extraction and WB/forwarding buses.
//               Optional misaligned-load check: define MEM_ALIGN_CHECK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_stage #(
  parameter int EX_TO_MEM_WD = 80,
  parameter int MEM_TO_WB_WD = 70,
  parameter int STALL_W      = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [STALL_W-1:0]      stall,
  input  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
  input  logic [31:0]             data_sram_rdata,
  output logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus,
  output logic [37:0]             mem_to_id,
  output logic                    mem_is_load,
  output logic                    mem_misalign
);
  import mem_stage_pkg::*;

  ex_mem_bus_t bus_q, bus_d;
  logic [31:0] rdata_hold_q, rdata_hold_d;
  logic        hold_vld_q, hold_vld_d;

  logic        w_bubble;
  logic        w_advance;
  logic [31:0] w_rdata_eff;
  logic [31:0] w_load_data;
  logic [31:0] w_rf_wdata;
  logic        w_rf_we;
  logic        w_misalign;
  logic        w_unused_ok;

  assign w_bubble  = (stall[3] == STOP) && (stall[4] == NO_STOP);
  assign w_advance = (stall[3] == NO_STOP);

  // The SRAM word is only valid in the first cycle the load sits in MEM,
  // so a stalled load latches it once and replays it until it moves on.
  always_comb begin
    bus_d        = bus_q;
    rdata_hold_d = rdata_hold_q;
    hold_vld_d   = hold_vld_q;
    if (w_bubble) begin
      bus_d      = '0;
      hold_vld_d = 1'b0;
    end else if (w_advance) begin
      bus_d      = ex_mem_bus_t'(ex_to_mem_bus);
      hold_vld_d = 1'b0;
    end else if (!hold_vld_q) begin
      rdata_hold_d = data_sram_rdata;
      hold_vld_d   = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus_q        <= '0;
      rdata_hold_q <= '0;
      hold_vld_q   <= 1'b0;
    end else begin
      bus_q        <= bus_d;
      rdata_hold_q <= rdata_hold_d;
      hold_vld_q   <= hold_vld_d;
    end
  end

  assign w_rdata_eff = hold_vld_q ? rdata_hold_q : data_sram_rdata;

  load_align u_load_align (
    .rdata_i     (w_rdata_eff),
    .addr_i      (bus_q.ex_result[1:0]),
    .readen_i    (bus_q.readen),
    .load_data_o (w_load_data)
  );

`ifdef MEM_ALIGN_CHECK_EN
  acc_size_e w_size;
  assign w_size     = decode_size(bus_q.readen);
  assign w_misalign = bus_q.sel_rf_res &&
                      (((w_size == ACC_HALF) && bus_q.ex_result[0]) ||
                       ((w_size == ACC_WORD) && (bus_q.ex_result[1:0] != 2'b00)));
`else
  assign w_misalign = 1'b0;
`endif

  assign w_rf_wdata = bus_q.sel_rf_res ? w_load_data : bus_q.ex_result;
  assign w_rf_we    = bus_q.rf_we & ~w_misalign;

  assign mem_to_wb_bus = {bus_q.pc, w_rf_we, bus_q.rf_waddr, w_rf_wdata};
  assign mem_to_id     = {w_rf_we, bus_q.rf_waddr, w_rf_wdata};
  assign mem_is_load   = bus_q.sel_rf_res & bus_q.ram_en;
  assign mem_misalign  = w_misalign;

  // Store byte enables and the remaining stall bits are owned by other stages.
  assign w_unused_ok = ^{bus_q.ram_wen, stall[2:0], stall[STALL_W-1:5]};

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_stage
// Description : Self-checking bench for mem_stage against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic [79:0] ex_bus;
  logic [31:0] rdata;
  logic [69:0] wb_bus;
  logic [37:0] id_bus;
  logic        is_load;
  logic        misalign;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: instruction currently in MEM and the word it saw on its first cycle.
  logic [79:0] m_bus;
  int          m_age;
  logic [31:0] m_first_word;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .ex_to_mem_bus   (ex_bus),
    .data_sram_rdata (rdata),
    .mem_to_wb_bus   (wb_bus),
    .mem_to_id       (id_bus),
    .mem_is_load     (is_load),
    .mem_misalign    (misalign)
  );

  task automatic check(input string tag, input logic [69:0] got, input logic [69:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [79:0] mk(input logic [3:0] rdn, input logic [31:0] pc,
                                     input logic ram_en, input logic sel, input logic we,
                                     input logic [4:0] waddr, input logic [31:0] res);
    return {rdn, pc, ram_en, 4'b0000, sel, we, waddr, res};
  endfunction

  function automatic logic [31:0] ext_load(input logic [3:0] rdn, input logic [1:0] a,
                                           input logic [31:0] w);
    logic [31:0] v;
    int unsigned sh;
    if (!rdn[2]) return w;
    if (rdn[1]) begin
      sh = a[1] ? 16 : 0;
      v  = (w >> sh) & 32'h0000FFFF;
      if (!rdn[3] && v >= 32'h8000) v = v + 32'hFFFF0000;
    end else begin
      sh = 8 * int'(a);
      v  = (w >> sh) & 32'h000000FF;
      if (!rdn[3] && v >= 32'h80) v = v + 32'hFFFFFF00;
    end
    return v;
  endfunction

  function automatic logic exp_misalign();
`ifdef MEM_ALIGN_CHECK_EN
    logic [3:0] rdn = m_bus[79:76];
    logic [1:0] a   = m_bus[1:0];
    if (!m_bus[38]) return 1'b0;
    if (rdn[2] && rdn[1]) return a[0];
    if (!rdn[2]) return (a != 2'b00);
    return 1'b0;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [69:0] exp_wb(input logic [31:0] live_word);
    logic [31:0] word;
    logic [31:0] wd;
    logic        we;
    word = (m_age == 0) ? live_word : m_first_word;
    wd   = m_bus[38] ? ext_load(m_bus[79:76], m_bus[1:0], word) : m_bus[31:0];
    we   = m_bus[37] && !exp_misalign();
    return {m_bus[75:44], we, m_bus[36:32], wd};
  endfunction

  task automatic compare_all();
    logic [69:0] e;
    e = exp_wb(rdata);
    check("wb_bus", wb_bus, e);
    check("id_bus", {32'd0, id_bus}, {32'd0, e[37:0]});
    check("is_load", {69'd0, is_load}, {69'd0, m_bus[38] & m_bus[43]});
    check("misalign", {69'd0, misalign}, {69'd0, exp_misalign()});
  endtask

  // Apply inputs just after an edge, then check in the middle of the cycle.
  task automatic drive(input logic [5:0] s, input logic [79:0] b, input logic [31:0] d);
    stall  = s;
    ex_bus = b;
    rdata  = d;
    @(negedge clk);
    compare_all();
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) begin
      m_bus = '0; m_age = 0; m_first_word = '0;
    end else if (stall[3] && !stall[4]) begin
      m_bus = '0; m_age = 0;
    end else if (!stall[3]) begin
      m_bus = ex_bus; m_age = 0;
    end else begin
      if (m_age == 0) m_first_word = rdata;
      m_age++;
    end
    #1;
  endtask

  function automatic logic [79:0] rand_bus();
    logic [3:0] codes [6];
    codes = '{4'b0001, 4'b0101, 4'b0111, 4'b1101, 4'b1111, 4'b0000};
    return {codes[$urandom_range(0, 5)], 32'($urandom), 1'($urandom), 4'($urandom),
            1'($urandom), 1'($urandom), 5'($urandom), 32'($urandom)};
  endfunction

  initial begin
    logic [79:0] nop;
    logic [5:0]  s;
    nop    = '0;
    rst    = 1'b1;
    stall  = '0;
    ex_bus = '0;
    rdata  = 32'hA5A5A5A5;
    m_bus = '0; m_age = 0; m_first_word = '0;
    #3;
    check("reset_wb", wb_bus, 70'd0);
    check("reset_id", {32'd0, id_bus}, 70'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // lb / lbu at byte 3
    drive(6'd0, mk(4'b0101, 32'h100, 1'b1, 1'b1, 1'b1, 5'd3, 32'h00001003), 32'h0); tick();
    drive(6'd0, mk(4'b1101, 32'h104, 1'b1, 1'b1, 1'b1, 5'd3, 32'h00001003), 32'h80FF1234);
    check("lb", {38'd0, wb_bus[31:0]}, {38'd0, 32'hFFFFFF80}); tick();
    drive(6'd0, mk(4'b0111, 32'h108, 1'b1, 1'b1, 1'b1, 5'd4, 32'h00002002), 32'h80FF1234);
    check("lbu", {38'd0, wb_bus[31:0]}, {38'd0, 32'h00000080}); tick();
    // lh upper half, lhu lower half
    drive(6'd0, mk(4'b1111, 32'h10C, 1'b1, 1'b1, 1'b1, 5'd4, 32'h00002000), 32'h8001ABCD);
    check("lh", {38'd0, wb_bus[31:0]}, {38'd0, 32'hFFFF8001}); tick();
    drive(6'd0, mk(4'b0001, 32'h110, 1'b1, 1'b1, 1'b1, 5'd6, 32'h00003000), 32'h8001ABCD);
    check("lhu", {38'd0, wb_bus[31:0]}, {38'd0, 32'h0000ABCD}); tick();

    // lw held three cycles while the SRAM word changes underneath
    drive(6'b011000, nop, 32'h11111111); tick();
    drive(6'b011000, nop, 32'h22222222); tick();
    drive(6'b011000, nop, 32'h22222222); tick();
    drive(6'd0, nop, 32'h22222222);
    check("lw_stall", {38'd0, wb_bus[31:0]}, {38'd0, 32'h11111111}); tick();

    // bubble insertion
    drive(6'b001000, mk(4'b0000, 32'h200, 1'b0, 1'b0, 1'b1, 5'd7, 32'h12345678), 32'h0); tick();
    drive(6'd0, mk(4'b0000, 32'h204, 1'b0, 1'b0, 1'b1, 5'd5, 32'hDEADBEEF), 32'h0);
    check("bubble_wb", wb_bus, 70'd0);
    check("bubble_id_we", {69'd0, id_bus[37]}, 70'd0); tick();

    // ALU forwarding, then asynchronous reset during a stall
    drive(6'b011000, nop, 32'h55555555);
    check("alu_fwd", {32'd0, id_bus}, {32'd0, 1'b1, 5'd5, 32'hDEADBEEF});
    #1 rst = 1'b1;
    #1;
    check("rst_wb", wb_bus, 70'd0);
    check("rst_id", {32'd0, id_bus}, 70'd0);
    check("rst_load", {69'd0, is_load}, 70'd0);
    tick();
    rst = 1'b0;

`ifdef MEM_ALIGN_CHECK_EN
    drive(6'd0, mk(4'b0001, 32'h300, 1'b1, 1'b1, 1'b1, 5'd9, 32'h00001002), 32'h0); tick();
    drive(6'd0, nop, 32'hCAFEF00D);
    check("misalign_flag", {69'd0, misalign}, {69'd0, 1'b1});
    check("misalign_we", {69'd0, wb_bus[37]}, 70'd0); tick();
`endif

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      s = '0;
      if ($urandom_range(0, 3) == 0) s[3] = 1'b1;
      if ($urandom_range(0, 1) == 0) s[4] = 1'b1;
      s[2:0] = 3'($urandom);
      drive(s, rand_bus(), $urandom);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
